ram_dp_clr: RTL and testbench



---
 rtl/ram_dp_clr.sv | 111 +++++++++++
 tb/tb_ram_dp_clr.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write, one registered read) with a built-in clear sequencer.
// Optional RAM_BYPASS_EN: same-cycle write/read to one address forwards the write data.
module ram_dp_clr #(
   parameter int  WORD_SIZE   = 32,
   parameter int  LENGTH_SIZE = 16,
   localparam int ADR_SIZE    = $clog2(LENGTH_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   output logic                 busy,
   input  logic                 wr,
   input  logic [ADR_SIZE-1:0]  wrAdr,
   input  logic [WORD_SIZE-1:0] dataIn,
   input  logic                 rd,
   input  logic [ADR_SIZE-1:0]  rdAdr,
   output logic [WORD_SIZE-1:0] dataOut,
   output logic                 dataValid
);

   // state | meaning
   // CLEAR | zeroing mem[clr_adr], one word per edge; busy, wr/rd/clr ignored
   // IDLE  | normal operation; clr restarts the clear sequence

   typedef enum logic {CLEAR, IDLE} state_t;

   localparam logic [ADR_SIZE:0]   LEN_EXT  = (ADR_SIZE+1)'(LENGTH_SIZE);
   localparam logic [ADR_SIZE-1:0] LAST_ADR = ADR_SIZE'(LENGTH_SIZE - 1);

   logic [WORD_SIZE-1:0] mem [LENGTH_SIZE];

   state_t               state, state_nxt;
   logic [ADR_SIZE-1:0]  clr_adr, clr_adr_nxt;
   logic                 mem_we;
   logic [ADR_SIZE-1:0]  mem_wa;
   logic [WORD_SIZE-1:0] mem_wd;
   logic                 rd_en;
   logic [WORD_SIZE-1:0] rd_word;
   logic                 wr_in_range, rd_in_range;

   assign wr_in_range = ({1'b0, wrAdr} < LEN_EXT);
   assign rd_in_range = ({1'b0, rdAdr} < LEN_EXT);

   always_comb begin
      state_nxt   = state;
      clr_adr_nxt = clr_adr;
      mem_we      = 1'b0;
      mem_wa      = wrAdr;
      mem_wd      = dataIn;
      rd_en       = 1'b0;
      unique case (state)
         CLEAR: begin
            mem_we = 1'b1;
            mem_wa = clr_adr;
            mem_wd = '0;
            if (clr_adr == LAST_ADR) begin
               state_nxt   = IDLE;
               clr_adr_nxt = '0;
            end else begin
               clr_adr_nxt = clr_adr + 1'b1;
            end
         end
         IDLE: begin
            if (clr) begin
               state_nxt   = CLEAR;
               clr_adr_nxt = '0;
            end else begin
               mem_we = wr && wr_in_range;
               rd_en  = rd;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Out-of-range reads return zero but are still flagged valid.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[rdAdr];
`ifdef RAM_BYPASS_EN
         if (wr && (wrAdr == rdAdr))
            rd_word = dataIn;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         clr_adr   <= '0;
         dataOut   <= '0;
         dataValid <= 1'b0;
      end else begin
         state     <= state_nxt;
         clr_adr   <= clr_adr_nxt;
         dataValid <= rd_en;
         if (rd_en)
            dataOut <= rd_word;
      end
   end

   // Memory array kept free of reset so it maps onto RAM macros.
   always_ff @(posedge clk) begin
      if (!rst && mem_we)
         mem[mem_wa] <= mem_wd;
   end

   assign busy = rst || (state == CLEAR);

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: directed cases plus random traffic against a word-array model,
// and a second 12-word instance for out-of-range addressing.
module tb_ram_dp_clr;

   localparam int W = 32;
   localparam int L = 16;
   localparam int A = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, clr, wr, rd;
   logic [A-1:0] wa, ra;
   logic [W-1:0] din;
   logic         busy, dv;
   logic [W-1:0] dout;

   ram_dp_clr #(.WORD_SIZE(W), .LENGTH_SIZE(L)) dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy),
      .wr(wr), .wrAdr(wa), .dataIn(din),
      .rd(rd), .rdAdr(ra), .dataOut(dout), .dataValid(dv)
   );

   logic         rst12, clr12, wr12, rd12;
   logic [3:0]   wa12, ra12;
   logic [W-1:0] din12;
   logic         busy12, dv12;
   logic [W-1:0] dout12;

   ram_dp_clr #(.WORD_SIZE(W), .LENGTH_SIZE(12)) dut12 (
      .clk(clk), .rst(rst12), .clr(clr12), .busy(busy12),
      .wr(wr12), .wrAdr(wa12), .dataIn(din12),
      .rd(rd12), .rdAdr(ra12), .dataOut(dout12), .dataValid(dv12)
   );

`ifdef RAM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   // Model: word array, count of clear edges still owed, expected read outputs.
   logic [W-1:0] m_mem [L];
   int           left;
   logic [W-1:0] e_out;
   logic         e_val;

   task automatic zero_model();
      foreach (m_mem[i]) m_mem[i] = '0;
      left = L;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst) begin
         zero_model();
         e_val = 1'b0;
         e_out = '0;
      end else if (left > 0) begin
         left--;
         e_val = 1'b0;
      end else if (clr) begin
         zero_model();
         e_val = 1'b0;
      end else begin
         e_val = rd;
         if (rd) begin
            if (int'(ra) >= L) e_out = '0;
            else if (BYPASS && wr && wa == ra) e_out = din;
            else e_out = m_mem[ra];
         end
         if (wr && int'(wa) < L) m_mem[wa] = din;
      end
      #1;
      chk("busy", 32'(busy), 32'(rst || left > 0));
      chk("dataValid", 32'(dv), 32'(e_val));
      chk("dataOut", dout, e_out);
   endtask

   task automatic idle();
      wr = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b0;
   endtask

   task automatic step12();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] v12 [12];

   initial begin
      rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; wa = '0; ra = '0; din = '0;
      rst12 = 1'b1; clr12 = 1'b0; wr12 = 1'b0; rd12 = 1'b0; wa12 = '0; ra12 = '0; din12 = '0;
      zero_model();
      e_out = '0; e_val = 1'b0;

      // reset clear: busy for exactly L edges after release, then all zeros
      repeat (3) cyc();
      rst = 1'b0;
      repeat (L - 1) cyc();
      chk("busy_last_clear", 32'(busy), 32'd1);
      cyc();
      chk("busy_done", 32'(busy), 32'd0);
      for (int i = 0; i < L; i++) begin
         rd = 1'b1; ra = A'(i);
         cyc();
      end
      idle();

      // write then read, then hold
      wr = 1'b1; wa = 4'd5; din = 32'hDEADBEEF;
      cyc();
      wr = 1'b0; rd = 1'b1; ra = 4'd5;
      cyc();
      chk("wr_rd", dout, 32'hDEADBEEF);
      chk("wr_rd_valid", 32'(dv), 32'd1);
      rd = 1'b0;
      cyc();
      chk("hold_data", dout, 32'hDEADBEEF);
      chk("hold_valid", 32'(dv), 32'd0);

      // same-cycle collision
      wr = 1'b1; wa = 4'd3; din = 32'h11;
      cyc();
      rd = 1'b1; ra = 4'd3; din = 32'h22;
      cyc();
      chk("collision", dout, BYPASS ? 32'h22 : 32'h11);
      wr = 1'b0;
      cyc();
      chk("after_collision", dout, 32'h22);
      idle();

      // clr in IDLE drops a same-cycle write
      for (int i = 0; i < L; i++) begin
         wr = 1'b1; wa = A'(i); din = 32'hA5A5A5A5;
         cyc();
      end
      clr = 1'b1; wa = 4'd0; din = 32'h1;
      cyc();
      clr = 1'b0; wr = 1'b0;
      repeat (L - 1) cyc();
      cyc();
      chk("clr_done", 32'(busy), 32'd0);
      for (int i = 0; i < L; i++) begin
         rd = 1'b1; ra = A'(i);
         cyc();
      end
      idle();

      // reset mid-clear restarts; clr while busy ignored
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      repeat (6) cyc();
      clr = 1'b1;
      cyc();
      clr = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (L - 1) cyc();
      chk("restart_busy", 32'(busy), 32'd1);
      cyc();
      chk("restart_done", 32'(busy), 32'd0);

      // reset during a read stream
      wr = 1'b1; wa = 4'd9; din = 32'hCAFE0009;
      cyc();
      wr = 1'b0; rd = 1'b1; ra = 4'd9;
      cyc();
      rst = 1'b1;
      cyc();
      chk("rst_read_valid", 32'(dv), 32'd0);
      chk("rst_read_data", dout, 32'd0);
      idle();
      repeat (L) cyc();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         clr = ($urandom_range(0, 63) == 0);
         wr  = 1'($urandom);
         rd  = 1'($urandom);
         wa  = A'($urandom);
         ra  = ($urandom_range(0, 3) == 0) ? wa : A'($urandom);
         din = $urandom;
         cyc();
      end
      idle();

      // 12-word instance: out-of-range write dropped, out-of-range read returns 0
      rst12 = 1'b0;
      repeat (11) step12();
      chk("l12_busy", 32'(busy12), 32'd1);
      step12();
      chk("l12_done", 32'(busy12), 32'd0);
      for (int i = 0; i < 12; i++) begin
         v12[i] = $urandom;
         wr12 = 1'b1; wa12 = 4'(i); din12 = v12[i];
         step12();
      end
      wa12 = 4'd13; din12 = 32'h77;
      step12();
      wr12 = 1'b0; rd12 = 1'b1; ra12 = 4'd13;
      step12();
      chk("l12_oor_data", dout12, 32'd0);
      chk("l12_oor_valid", 32'(dv12), 32'd1);
      for (int i = 0; i < 12; i++) begin
         ra12 = 4'(i);
         step12();
         chk("l12_word", dout12, v12[i]);
      end
      rd12 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
